// File: rtl/window_gen3x3.sv
// 3x3 sliding-window generator over a raster pixel stream, with zero-fill or
// clamp handling of neighbours that fall outside the image.
`timescale 1ns/1ps
module window_gen3x3 #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int PIX_W       = 8,
  parameter int BORDER_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             in_ready,
  output logic [PIX_W-1:0] p0,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             out_border
);

  // state | meaning
  // FILL  | priming line buffers, no windows yet for this frame
  // RUN   | one window per accepted pixel, centred IMG_W+1 pixels behind
  // FLUSH | input stalled, emitting the last IMG_W+1 windows from stored data
  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam bit CLAMP = (BORDER_MODE == 1);

  state_t           state;
  logic [CW-1:0]    col, ccol;
  logic [RW-1:0]    row, crow;
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] win [3][3];
  logic [PIX_W-1:0] nxt [3][3];
  logic [PIX_W-1:0] rfix [3][3];
  logic [PIX_W-1:0] fx [3][3];
  logic [PIX_W-1:0] newcol [3];
  logic [PIX_W-1:0] pout [9];
  logic             flushing, acc, adv, emit, last_in, last_out;

  assign in_ready = ~rst & (state != FLUSH);
  assign flushing = (state == FLUSH);
  assign acc      = in_valid & in_ready;
  assign adv      = acc | flushing;
  assign last_in  = (row == ROW_LAST) & (col == COL_LAST);
  assign last_out = (crow == ROW_LAST) & (ccol == COL_LAST);
  assign emit     = flushing |
                    (acc & ((state == RUN) |
                            ((state == FILL) & (row == RW'(1)) & (col == CW'(1)))));

  // The right column of the shifted window is always the newest data; the
  // middle column holds the centre. Out-of-image rows/columns are replaced
  // here, which also hides the wrapped columns at line boundaries.
  always_comb begin
    newcol[0] = lb1[col];
    newcol[1] = lb0[col];
    newcol[2] = flushing ? '0 : in_pixel;
    for (int i = 0; i < 3; i++) begin
      nxt[i][0] = win[i][1];
      nxt[i][1] = win[i][2];
      nxt[i][2] = newcol[i];
    end
    for (int j = 0; j < 3; j++) begin
      rfix[0][j] = (crow == '0)      ? (CLAMP ? nxt[1][j] : '0) : nxt[0][j];
      rfix[1][j] = nxt[1][j];
      rfix[2][j] = (crow == ROW_LAST) ? (CLAMP ? nxt[1][j] : '0) : nxt[2][j];
    end
    for (int i = 0; i < 3; i++) begin
      fx[i][0] = (ccol == '0)      ? (CLAMP ? rfix[i][1] : '0) : rfix[i][0];
      fx[i][1] = rfix[i][1];
      fx[i][2] = (ccol == COL_LAST) ? (CLAMP ? rfix[i][1] : '0) : rfix[i][2];
    end
  end

  // Line buffers and raw window carry no reset: stale entries are always masked.
  always_ff @(posedge clk) begin
    if (adv) begin
      lb1[col] <= lb0[col];
      lb0[col] <= newcol[2];
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= nxt[i][0];
        win[i][1] <= nxt[i][1];
        win[i][2] <= nxt[i][2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      col        <= '0;
      row        <= '0;
      ccol       <= '0;
      crow       <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
      out_border <= 1'b0;
      for (int k = 0; k < 9; k++) pout[k] <= '0;
    end else begin
      out_valid  <= emit;
      out_sof    <= emit & (crow == '0) & (ccol == '0);
      out_eol    <= emit & (ccol == COL_LAST);
      out_eof    <= emit & last_out;
      out_border <= emit & ((crow == '0) | (crow == ROW_LAST) |
                            (ccol == '0) | (ccol == COL_LAST));

      if (adv) begin
        if (col == COL_LAST) begin
          col <= '0;
          if (acc) row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      if (emit) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            pout[3*i+j] <= fx[i][j];
        if (ccol == COL_LAST) begin
          ccol <= '0;
          crow <= (crow == ROW_LAST) ? '0 : crow + RW'(1);
        end else begin
          ccol <= ccol + CW'(1);
        end
      end

      case (state)
        FILL:  if (emit) state <= RUN;
        RUN:   if (acc && last_in) state <= FLUSH;
        FLUSH: if (last_out) begin
          state <= FILL;
          col   <= '0;
          row   <= '0;
        end
        default: state <= FILL;
      endcase
    end
  end

  assign p0 = pout[0];
  assign p1 = pout[1];
  assign p2 = pout[2];
  assign p3 = pout[3];
  assign p4 = pout[4];
  assign p5 = pout[5];
  assign p6 = pout[6];
  assign p7 = pout[7];
  assign p8 = pout[8];

endmodule

// File: tb/tb_window_gen3x3.sv
// Directed bench for window_gen3x3 on a 4x3 image, zero-fill and clamp variants
// driven in lockstep.
`timescale 1ns/1ps
module tb_window_gen3x3;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct packed {
    logic [8:0][7:0] p;
    logic sof, eol, eof, border;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_pixel = 8'd0;
  logic rdy0, rdy1;
  logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
  logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
  logic av, asof, aeol, aeof, abrd;
  logic bv, bsof, beol, beof, bbrd;

  int n_assert = 0;
  int n_fail = 0;
  win_t q0[$];
  win_t q1[$];
  int runs[$];
  int low_run = 0;

  always #5 clk = ~clk;

  window_gen3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .BORDER_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(rdy0),
    .p0(a0), .p1(a1), .p2(a2), .p3(a3), .p4(a4), .p5(a5), .p6(a6), .p7(a7), .p8(a8),
    .out_valid(av), .out_sof(asof), .out_eol(aeol), .out_eof(aeof), .out_border(abrd));

  window_gen3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .BORDER_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(rdy1),
    .p0(b0), .p1(b1), .p2(b2), .p3(b3), .p4(b4), .p5(b5), .p6(b6), .p7(b7), .p8(b8),
    .out_valid(bv), .out_sof(bsof), .out_eol(beol), .out_eof(beof), .out_border(bbrd));

  function automatic win_t pk(logic [7:0] x0, logic [7:0] x1, logic [7:0] x2,
                              logic [7:0] x3, logic [7:0] x4, logic [7:0] x5,
                              logic [7:0] x6, logic [7:0] x7, logic [7:0] x8,
                              logic s, logic l, logic f, logic b);
    win_t w;
    w.p[0] = x0; w.p[1] = x1; w.p[2] = x2;
    w.p[3] = x3; w.p[4] = x4; w.p[5] = x5;
    w.p[6] = x6; w.p[7] = x7; w.p[8] = x8;
    w.sof = s; w.eol = l; w.eof = f; w.border = b;
    return w;
  endfunction

  function automatic win_t mk(int e[9], bit s, bit l, bit f, bit b);
    win_t w;
    for (int k = 0; k < 9; k++) w.p[k] = 8'(e[k]);
    w.sof = s; w.eol = l; w.eof = f; w.border = b;
    return w;
  endfunction

  // Image pixel (r,c) = r*W + c + 1; neighbours outside are 0 or clamped.
  function automatic win_t ref_win(int n, int bm);
    win_t w;
    int r, c, rr, cc, v;
    r = n / W;
    c = n % W;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        rr = r + i - 1;
        cc = c + j - 1;
        if (rr < 0 || rr >= H || cc < 0 || cc >= W) begin
          if (bm == 0) begin
            v = 0;
          end else begin
            rr = (rr < 0) ? 0 : ((rr >= H) ? H - 1 : rr);
            cc = (cc < 0) ? 0 : ((cc >= W) ? W - 1 : cc);
            v = rr * W + cc + 1;
          end
        end else begin
          v = rr * W + cc + 1;
        end
        w.p[3*i+j] = 8'(v);
      end
    end
    w.sof = (n == 0);
    w.eol = (c == W - 1);
    w.eof = (n == N - 1);
    w.border = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
    return w;
  endfunction

  always @(negedge clk) begin
    if (av) q0.push_back(pk(a0, a1, a2, a3, a4, a5, a6, a7, a8, asof, aeol, aeof, abrd));
    if (bv) q1.push_back(pk(b0, b1, b2, b3, b4, b5, b6, b7, b8, bsof, beol, beof, bbrd));
    if (!rst) begin
      if (!rdy0) low_run++;
      else if (low_run > 0) begin
        runs.push_back(low_run);
        low_run = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input int first, input int count, input bit gaps);
    int t;
    bit ok;
    for (int v = first; v < first + count; v++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      in_valid = 1'b1;
      in_pixel = 8'(v);
      t = 0;
      forever begin
        ok = rdy0;
        tick();
        if (ok) break;
        t++;
        if (t > 50) begin
          check("accept_timeout", 76'(t), 76'(0));
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_wins(input string tag, input int n);
    int t;
    t = 0;
    while ((q0.size() < n || q1.size() < n) && t < 200) begin
      tick();
      t++;
    end
    repeat (8) tick();
    check({tag, "_count0"}, 76'(q0.size()), 76'(n));
    check({tag, "_count1"}, 76'(q1.size()), 76'(n));
  endtask

  task automatic check_frame(input string tag, input int base);
    win_t o;
    for (int n = 0; n < N; n++) begin
      o = (base + n < q0.size()) ? q0[base+n] : '0;
      check($sformatf("%s_zero_w%0d", tag, n), o, ref_win(n, 0));
      o = (base + n < q1.size()) ? q1[base+n] : '0;
      check($sformatf("%s_clamp_w%0d", tag, n), o, ref_win(n, 1));
    end
  endtask

  task automatic clear_logs();
    q0.delete();
    q1.delete();
    runs.delete();
    low_run = 0;
  endtask

  initial begin
    int nq, neol;
    win_t o;

    // reset state
    repeat (3) tick();
    check("reset_in_ready", 76'(rdy0), 76'(0));
    check("reset_out_valid", 76'(av), 76'(0));
    check("reset_p4", 76'(a4), 76'(0));
    check("reset_flags", 76'({asof, aeol, aeof, abrd}), 76'(0));
    rst = 1'b0;
    #1;
    check("ready_after_reset", 76'(rdy0), 76'(1));

    // frame A: back-to-back 1..12, latency of first window
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_pixel = 8'(k + 1);
      tick();
      if (k == 4) check("no_valid_after_5th", 76'(av), 76'(0));
      if (k == 5) check("valid_after_6th", 76'(av), 76'(1));
    end
    in_valid = 1'b0;
    wait_wins("A", N);
    check_frame("A", 0);
    o = (q0.size() > 5) ? q0[5] : '0;
    check("A_zero_centre11", o, mk('{1, 2, 3, 5, 6, 7, 9, 10, 11}, 0, 0, 0, 0));
    o = (q0.size() > 0) ? q0[0] : '0;
    check("A_zero_origin", o, mk('{0, 0, 0, 0, 1, 2, 0, 5, 6}, 1, 0, 0, 1));
    o = (q1.size() > 0) ? q1[0] : '0;
    check("A_clamp_origin", o, mk('{1, 1, 2, 1, 1, 2, 5, 5, 6}, 1, 0, 0, 1));
    o = (q1.size() > 11) ? q1[11] : '0;
    check("A_clamp_last", o, mk('{7, 8, 8, 11, 12, 12, 11, 12, 12}, 0, 1, 1, 1));
    check("A_flush_len", 76'((runs.size() == 1) ? runs[0] : 99), 76'(5));

    // back-to-back frames
    clear_logs();
    send_pix(1, N, 1'b0);
    send_pix(1, N, 1'b0);
    wait_wins("B", 2 * N);
    check_frame("B1", 0);
    check_frame("B2", N);
    check("B_flush_runs", 76'(runs.size()), 76'(2));
    check("B_flush_len0", 76'((runs.size() > 0) ? runs[0] : 99), 76'(5));
    check("B_flush_len1", 76'((runs.size() > 1) ? runs[1] : 99), 76'(5));
    neol = 0;
    foreach (q0[i]) if (q0[i].eol) neol++;
    check("B_eol_count", 76'(neol), 76'(6));

    // random input gaps
    clear_logs();
    send_pix(1, N, 1'b1);
    wait_wins("G", N);
    check_frame("G", 0);

    // reset after 7 accepted pixels
    clear_logs();
    send_pix(1, 7, 1'b0);
    repeat (2) tick();
    clear_logs();
    rst = 1'b1;
    repeat (2) tick();
    check("R_reset_p4", 76'(a4), 76'(0));
    check("R_reset_valid", 76'(av), 76'(0));
    rst = 1'b0;
    repeat (6) tick();
    check("R_no_stale_windows", 76'(q0.size()), 76'(0));
    send_pix(1, N, 1'b0);
    wait_wins("R", N);
    check_frame("R", 0);
    o = (q0.size() > 5) ? q0[5] : '0;
    check("R_zero_centre11", o, mk('{1, 2, 3, 5, 6, 7, 9, 10, 11}, 0, 0, 0, 0));

    // reset during flush
    clear_logs();
    send_pix(1, N, 1'b0);
    repeat (2) tick();
    check("F_in_flush", 76'(rdy0), 76'(0));
    rst = 1'b1;
    tick();
    nq = q0.size();
    rst = 1'b0;
    repeat (8) tick();
    check("F_no_windows_after_reset", 76'(q0.size()), 76'(nq));
    clear_logs();
    send_pix(1, N, 1'b0);
    wait_wins("F", N);
    check_frame("F", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/window_gen3x3.md
WINDOW_GEN3X3 -- requirements
Module: window_gen3x3

Interface
REQ-001 The block SHALL have parameter IMG_W, default 640, meaning pixels per line (>=3).
REQ-002 The block SHALL have parameter IMG_H, default 480, meaning lines per frame (>=3).
REQ-003 The block SHALL have parameter PIX_W, default 8, meaning bits per pixel.
REQ-004 The block SHALL have parameter BORDER_MODE, default 0, meaning out-of-image neighbour policy: 0 = zero fill, 1 = replicate nearest edge pixel (clamp).
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic on posedge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning in_pixel carries the next raster-order pixel.
REQ-008 The block SHALL have port in_pixel, input, PIX_W bits, meaning the input pixel.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning an input is accepted on a cycle when in_valid & in_ready.
REQ-010 The block SHALL have ports p0..p8, output, PIX_W bits each, meaning the 3x3 window in row-major order, with p4 the centre.
REQ-011 The block SHALL have port out_valid, output, 1 bit, meaning p0..p8 and the flags are valid this cycle; no backpressure.
REQ-012 The block SHALL have ports out_sof, out_eol and out_eof, outputs, 1 bit each, meaning the window is centred on pixel (0,0), the last column, and the last pixel of the frame, respectively.
REQ-013 The block SHALL have port out_border, output, 1 bit, meaning the centre lies in row 0, row IMG_H-1, column 0 or column IMG_W-1.

Function
REQ-014 Storage SHALL be two IMG_W-deep line buffers of PIX_W bits plus a 3x3 register window; no full-frame memory.
REQ-015 Input pixels SHALL be counted with a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1), both advancing only on accepted inputs; the column wraps to 0 and the row increments at IMG_W-1.
REQ-016 The FSM SHALL have three states: FILL, RUN and FLUSH.
REQ-017 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0; the FSM SHALL move to RUN on acceptance of input index IMG_W+1 (row 1, column 1).
REQ-018 In RUN, each accepted input SHALL produce exactly one output window one cycle later, centred on input index (k - IMG_W - 1); cycles without an accepted input SHALL produce out_valid = 0.
REQ-019 On acceptance of the final pixel (row IMG_H-1, column IMG_W-1), the FSM SHALL enter FLUSH on the next cycle.
REQ-020 In FLUSH, in_ready SHALL be 0, and the block SHALL emit the remaining IMG_W+1 windows on consecutive cycles with out_valid = 1, using the border policy in place of the missing inputs.
REQ-021 After the window carrying out_eof is emitted, the FSM SHALL return to FILL with both counters at 0, ready for the next frame.
REQ-022 Each frame SHALL yield exactly IMG_W*IMG_H windows in raster order, with out_sof, out_eol and out_eof each asserted only together with out_valid.
REQ-023 Any neighbour outside the image SHALL be 0 when BORDER_MODE = 0, and SHALL be the clamped in-image pixel (row/column saturated to [0, dimension-1]) when BORDER_MODE = 1.
REQ-024 In-image neighbours SHALL always carry their true values, including those of border centres.
REQ-025 Horizontal wrap SHALL never occur: column 0 SHALL never take data from the previous line's last column, and vice versa.
REQ-026 Output data SHALL be registered; p0..p8 SHALL hold their last value when out_valid = 0.
REQ-027 Gaps in in_valid SHALL only stall the pipeline and SHALL NOT change the output data or the output order.

Reset
REQ-028 While rst = 1: state = FILL, counters = 0, out_valid = out_sof = out_eol = out_eof = out_border = 0, p0..p8 = 0, and in_ready = 0.
REQ-029 In the first cycle after rst falls, in_ready SHALL be 1.
REQ-030 Reset asserted mid-frame, including during FLUSH, SHALL abort the frame; no further windows from that frame SHALL be emitted, and the next accepted pixel SHALL be treated as (0,0).
REQ-031 Line-buffer contents SHALL NOT need reset, because no stale data reaches an output after FILL.

Verification
REQ-032 With IMG_W=4, IMG_H=3, BORDER_MODE=0 and values 1..12 fed back-to-back: first out_valid one cycle after the 6th accept; centre (1,1) gives p0..p8 = 1,2,3,5,6,7,9,10,11; (0,0) gives 0,0,0,0,1,2,0,5,6 with out_sof=1 and out_border=1.
REQ-033 The same stimulus with BORDER_MODE=1: (0,0) gives 1,1,2,1,1,2,5,5,6; (2,3) gives 7,8,8,11,12,12,11,12,12 with out_eof=1.
REQ-034 Back-to-back frames: exactly 12 windows per frame; in_ready = 0 for exactly 5 FLUSH cycles; out_eol on every 4th window.
REQ-035 Random in_valid gaps (50% duty): the window sequence SHALL be identical to the gap-free run.
REQ-036 Reset pulse after 7 accepted pixels, then a fresh frame: no windows from the aborted frame; the new frame's outputs SHALL match REQ-032.
REQ-037 At the default 640x480 with a ramp image: exactly 307200 windows, out_border count = 2*640+2*478 = 2236.
